// File: rtl/voice_allocator.sv
// Polyphonic voice scheduler: scans channels one per cycle for a key hit or free voice,
// then writes the chosen channel (retrigger, free voice, or round-robin steal).
module voice_allocator #(
    parameter int NUM_CHANNELS = 16,
    parameter int NUM_BITS     = 32,
    parameter int KEY_BITS     = 7,
    parameter int VEL_BITS     = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ev_valid,
    output logic                             ev_ready,
    input  logic                             ev_note_on,
    input  logic [KEY_BITS-1:0]              ev_key,
    input  logic [VEL_BITS-1:0]              ev_velocity,
    input  logic [NUM_BITS-1:0]              ev_car_word,
    input  logic [NUM_BITS-1:0]              ev_mod_word,
    input  logic [NUM_CHANNELS-1:0]          available,
    output logic [NUM_BITS*NUM_CHANNELS-1:0] carrier_out,
    output logic [NUM_BITS*NUM_CHANNELS-1:0] modulator_out,
    output logic [NUM_BITS*NUM_CHANNELS-1:0] velocity_out,
    output logic [NUM_CHANNELS-1:0]          gate_out,
    output logic                             steal,
    output logic                             busy
);
    // state | meaning
    // IDLE  | waiting for an event, ev_ready high
    // SCAN  | examining channel idx for hit/free, plus one closing cycle
    // WRITE | update target channel registers, return to IDLE
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam int IDX_BITS = $clog2(NUM_CHANNELS);
    localparam logic [IDX_BITS:0] SCAN_END = (IDX_BITS+1)'(NUM_CHANNELS);

    logic [1:0]                        state_q, state_d;
    logic [IDX_BITS:0]                 idx_q, idx_d;
    logic                              note_on_q, note_on_d;
    logic [KEY_BITS-1:0]               key_lat_q, key_lat_d;
    logic [VEL_BITS-1:0]               vel_lat_q, vel_lat_d;
    logic [NUM_BITS-1:0]               car_lat_q, car_lat_d;
    logic [NUM_BITS-1:0]               mod_lat_q, mod_lat_d;
    logic                              hit_vld_q, hit_vld_d;
    logic [IDX_BITS-1:0]               hit_idx_q, hit_idx_d;
    logic                              free_vld_q, free_vld_d;
    logic [IDX_BITS-1:0]               free_idx_q, free_idx_d;
    logic [IDX_BITS-1:0]               steal_ptr_q, steal_ptr_d;
    logic [KEY_BITS*NUM_CHANNELS-1:0]  key_q, key_d;
    logic [NUM_CHANNELS-1:0]           active_q, active_d;
    logic [NUM_BITS*NUM_CHANNELS-1:0]  car_q, car_d;
    logic [NUM_BITS*NUM_CHANNELS-1:0]  mod_q, mod_d;
    logic [NUM_BITS*NUM_CHANNELS-1:0]  vel_q, vel_d;
    logic                              steal_q, steal_d;

    logic [IDX_BITS-1:0] ch;
    logic [IDX_BITS-1:0] tgt;
    logic                from_steal;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        note_on_d   = note_on_q;
        key_lat_d   = key_lat_q;
        vel_lat_d   = vel_lat_q;
        car_lat_d   = car_lat_q;
        mod_lat_d   = mod_lat_q;
        hit_vld_d   = hit_vld_q;
        hit_idx_d   = hit_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        steal_ptr_d = steal_ptr_q;
        key_d       = key_q;
        active_d    = active_q;
        car_d       = car_q;
        mod_d       = mod_q;
        vel_d       = vel_q;
        steal_d     = 1'b0;
        ch          = idx_q[IDX_BITS-1:0];
        tgt         = '0;
        from_steal  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ev_valid) begin
                    note_on_d  = ev_note_on;
                    key_lat_d  = ev_key;
                    vel_lat_d  = ev_velocity;
                    car_lat_d  = ev_car_word;
                    mod_lat_d  = ev_mod_word;
                    idx_d      = '0;
                    hit_vld_d  = 1'b0;
                    free_vld_d = 1'b0;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (idx_q == SCAN_END) begin
                    state_d = S_WRITE;
                end else begin
                    if (!hit_vld_q && active_q[ch] &&
                        key_q[ch*KEY_BITS +: KEY_BITS] == key_lat_q) begin
                        hit_vld_d = 1'b1;
                        hit_idx_d = ch;
                    end
                    // a released voice still in its envelope tail is not free
                    if (!free_vld_q && !active_q[ch] && available[ch]) begin
                        free_vld_d = 1'b1;
                        free_idx_d = ch;
                    end
                    idx_d = idx_q + 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
                if (note_on_q) begin
                    if (hit_vld_q) begin
                        tgt = hit_idx_q;
                    end else if (free_vld_q) begin
                        tgt = free_idx_q;
                    end else begin
                        tgt        = steal_ptr_q;
                        from_steal = 1'b1;
                    end
                    car_d[tgt*NUM_BITS +: NUM_BITS]   = car_lat_q;
                    mod_d[tgt*NUM_BITS +: NUM_BITS]   = mod_lat_q;
                    vel_d[tgt*NUM_BITS +: NUM_BITS]   = NUM_BITS'(vel_lat_q);
                    key_d[tgt*KEY_BITS +: KEY_BITS]   = key_lat_q;
                    active_d[tgt]                     = 1'b1;
                    if (from_steal) begin
                        steal_d     = 1'b1;
                        steal_ptr_d = steal_ptr_q + 1'b1;
                    end
                end else if (hit_vld_q) begin
                    // words are held so the release envelope keeps sounding
                    active_d[hit_idx_q] = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            note_on_q   <= 1'b0;
            key_lat_q   <= '0;
            vel_lat_q   <= '0;
            car_lat_q   <= '0;
            mod_lat_q   <= '0;
            hit_vld_q   <= 1'b0;
            hit_idx_q   <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            steal_ptr_q <= '0;
            key_q       <= '0;
            active_q    <= '0;
            car_q       <= '0;
            mod_q       <= '0;
            vel_q       <= '0;
            steal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            note_on_q   <= note_on_d;
            key_lat_q   <= key_lat_d;
            vel_lat_q   <= vel_lat_d;
            car_lat_q   <= car_lat_d;
            mod_lat_q   <= mod_lat_d;
            hit_vld_q   <= hit_vld_d;
            hit_idx_q   <= hit_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            steal_ptr_q <= steal_ptr_d;
            key_q       <= key_d;
            active_q    <= active_d;
            car_q       <= car_d;
            mod_q       <= mod_d;
            vel_q       <= vel_d;
            steal_q     <= steal_d;
        end
    end

    assign ev_ready      = (state_q == S_IDLE) && rst;
    assign busy          = (state_q != S_IDLE);
    assign carrier_out   = car_q;
    assign modulator_out = mod_q;
    assign velocity_out  = vel_q;
    assign gate_out      = active_q;
    assign steal         = steal_q;
endmodule
